// File: rtl/capture_buffer_sequencer_if.sv
`default_nettype none
// ============================================================================
// capture_buffer_sequencer_if
// Control/status bundle between the capture controller and the sequencer.
// Revision: 1.0
// ============================================================================
interface capture_buffer_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic              sample_valid;
  logic              trig_hit;
  logic [ADDR_W-1:0] pre_depth;
  logic [ADDR_W-1:0] post_depth;
  logic              rd_start;
  logic              rd_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              saw_trigger;
  logic              capture_complete;
  logic              rd_done;
  logic              idle;
  logic              armed;
  logic              busy;
  logic              data_ready;

  modport master (
    output start, abort, sample_valid, trig_hit, pre_depth, post_depth, rd_start, rd_next,
    input  mem_we, mem_waddr, mem_raddr, trig_addr, saw_trigger, capture_complete,
           rd_done, idle, armed, busy, data_ready
  );

  modport slave (
    input  start, abort, sample_valid, trig_hit, pre_depth, post_depth, rd_start, rd_next,
    output mem_we, mem_waddr, mem_raddr, trig_addr, saw_trigger, capture_complete,
           rd_done, idle, armed, busy, data_ready
  );
endinterface
`default_nettype wire

// File: rtl/capture_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// capture_buffer_sequencer
// Write/read pointer sequencing for the circular capture sample RAM.
// Revision: 1.0
// ============================================================================
module capture_buffer_sequencer #(
  parameter int ADDR_W = 10
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  capture_buffer_sequencer_if.slave        bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4,
    S_READ  = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nxt;
  logic [ADDR_W-1:0] r_pre, w_pre_nxt;
  logic [ADDR_W-1:0] r_post, w_post_nxt;
  logic [ADDR_W-1:0] r_pre_cnt, w_pre_cnt_nxt;
  logic [ADDR_W-1:0] r_post_cnt, w_post_cnt_nxt;
  logic [ADDR_W:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic              r_saw, w_saw_nxt;
  logic              r_cmp, w_cmp_nxt;
  logic              r_rdd, w_rdd_nxt;

  logic [ADDR_W-1:0] w_pre_cnt_inc;
  logic [ADDR_W-1:0] w_post_cnt_inc;
  logic [ADDR_W:0]   w_rd_cnt_inc;
  logic [ADDR_W:0]   w_rd_total;
  logic [ADDR_W-1:0] w_rd_first;

  assign w_pre_cnt_inc  = r_pre_cnt + ADDR_W'(1);
  assign w_post_cnt_inc = r_post_cnt + ADDR_W'(1);
  assign w_rd_cnt_inc   = r_rd_cnt + (ADDR_W+1)'(1);
  assign w_rd_total     = {1'b0, r_pre} + {1'b0, r_post};
  assign w_rd_first     = r_trig_addr - r_pre;

  always_comb begin
    w_state_nxt     = r_state;
    w_waddr_nxt     = r_waddr;
    w_raddr_nxt     = r_raddr;
    w_trig_addr_nxt = r_trig_addr;
    w_pre_nxt       = r_pre;
    w_post_nxt      = r_post;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_post_cnt_nxt  = r_post_cnt;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_saw_nxt       = 1'b0;
    w_cmp_nxt       = 1'b0;
    w_rdd_nxt       = 1'b0;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && bus.start) begin
      // Post depth of zero still stores the trigger sample itself.
      w_pre_nxt      = bus.pre_depth;
      w_post_nxt     = (bus.post_depth == '0) ? ADDR_W'(1) : bus.post_depth;
      w_waddr_nxt    = '0;
      w_pre_cnt_nxt  = '0;
      w_post_cnt_nxt = '0;
      w_state_nxt    = (bus.pre_depth == '0) ? S_ARMED : S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.sample_valid) begin
            w_waddr_nxt   = r_waddr + ADDR_W'(1);
            w_pre_cnt_nxt = w_pre_cnt_inc;
            if (w_pre_cnt_inc == r_pre) w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.sample_valid) begin
            w_waddr_nxt = r_waddr + ADDR_W'(1);
            if (bus.trig_hit) begin
              w_trig_addr_nxt = r_waddr;
              w_saw_nxt       = 1'b1;
              w_post_cnt_nxt  = ADDR_W'(1);
              if (r_post == ADDR_W'(1)) begin
                w_cmp_nxt   = 1'b1;
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (bus.sample_valid) begin
            w_waddr_nxt    = r_waddr + ADDR_W'(1);
            w_post_cnt_nxt = w_post_cnt_inc;
            if (w_post_cnt_inc == r_post) begin
              w_cmp_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.rd_start) begin
            w_raddr_nxt  = w_rd_first;
            w_rd_cnt_nxt = '0;
            w_state_nxt  = S_READ;
          end
        end
        S_READ: begin
          if (bus.rd_start) begin
            w_raddr_nxt  = w_rd_first;
            w_rd_cnt_nxt = '0;
          end else if (bus.rd_next) begin
            // Last sample leaves the read address on the final location.
            if (w_rd_cnt_inc == w_rd_total) begin
              w_rdd_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_raddr_nxt  = r_raddr + ADDR_W'(1);
              w_rd_cnt_nxt = w_rd_cnt_inc;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_trig_addr <= '0;
      r_pre       <= '0;
      r_post      <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_saw       <= 1'b0;
      r_cmp       <= 1'b0;
      r_rdd       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_waddr     <= w_waddr_nxt;
      r_raddr     <= w_raddr_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_pre       <= w_pre_nxt;
      r_post      <= w_post_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_post_cnt  <= w_post_cnt_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_saw       <= w_saw_nxt;
      r_cmp       <= w_cmp_nxt;
      r_rdd       <= w_rdd_nxt;
    end
  end

  assign bus.busy             = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign bus.mem_we           = bus.sample_valid && bus.busy;
  assign bus.mem_waddr        = r_waddr;
  assign bus.mem_raddr        = r_raddr;
  assign bus.trig_addr        = r_trig_addr;
  assign bus.saw_trigger      = r_saw;
  assign bus.capture_complete = r_cmp;
  assign bus.rd_done          = r_rdd;
  assign bus.idle             = (r_state == S_IDLE);
  assign bus.armed            = (r_state == S_ARMED);
  assign bus.data_ready       = (r_state == S_DONE) || (r_state == S_READ);
endmodule
`default_nettype wire

// File: tb/tb_capture_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_capture_buffer_sequencer
// Directed vector table plus hand sequences for the capture buffer sequencer.
// Revision: 1.0
// ============================================================================
module tb_capture_buffer_sequencer;
  localparam int ADDR_W = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_saw;
  int   n_cmp;
  int   n_rdd;

  capture_buffer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  capture_buffer_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, sv, tg, rs, rn;
    logic       we;
    logic [3:0] waddr, raddr, trig;
    logic [2:0] pulses;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic sv, logic tg, logic rs, logic rn, logic we,
                              int wa, int ra, int ta, logic [2:0] pl, logic [3:0] fl);
    vec_t v;
    v.st = st; v.sv = sv; v.tg = tg; v.rs = rs; v.rn = rn; v.we = we;
    v.waddr = 4'(wa); v.raddr = 4'(ra); v.trig = 4'(ta);
    v.pulses = pl; v.flags = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.idle, bus.armed, bus.busy, bus.data_ready};
  endfunction

  task automatic drive(input logic st, input logic ab, input logic sv, input logic tg,
                       input logic rs, input logic rn);
    bus.start = st; bus.abort = ab; bus.sample_valid = sv;
    bus.trig_hit = tg; bus.rd_start = rs; bus.rd_next = rn;
  endtask

  task automatic cyc(input logic st, input logic ab, input logic sv, input logic tg,
                     input logic rs, input logic rn);
    @(negedge clk);
    drive(st, ab, sv, tg, rs, rn);
    @(posedge clk);
    #1;
    if (bus.saw_trigger) n_saw++;
    if (bus.capture_complete) n_cmp++;
    if (bus.rd_done) n_rdd++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    n_saw = 0; n_cmp = 0; n_rdd = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_saw = 0; n_cmp = 0; n_rdd = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    bus.pre_depth = 4'd4;
    bus.post_depth = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", flags(), 4'b1000);
    chk("reset_waddr", bus.mem_waddr, 0);
    chk("reset_raddr", bus.mem_raddr, 0);
    chk("reset_trig", bus.trig_addr, 0);
    chk("reset_pulses", {bus.saw_trigger, bus.capture_complete, bus.rd_done}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Scenario: pre=4 post=4, trigger on sixth sample, then full readout.
    vecs.push_back(mk(1,0,0,0,0, 0, 0,0,0, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 1,0,0, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 2,0,0, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 3,0,0, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 4,0,0, 3'b000, 4'b0110));
    vecs.push_back(mk(0,1,0,0,0, 1, 5,0,0, 3'b000, 4'b0110));
    vecs.push_back(mk(0,1,1,0,0, 1, 6,0,5, 3'b100, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 7,0,5, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 8,0,5, 3'b000, 4'b0010));
    vecs.push_back(mk(0,1,0,0,0, 1, 9,0,5, 3'b010, 4'b0001));
    vecs.push_back(mk(0,0,0,0,0, 0, 9,0,5, 3'b000, 4'b0001));
    vecs.push_back(mk(0,0,0,1,0, 0, 9,1,5, 3'b000, 4'b0001));
    for (int k = 2; k <= 8; k++)
      vecs.push_back(mk(0,0,0,0,1, 0, 9,k,5, 3'b000, 4'b0001));
    vecs.push_back(mk(0,0,0,0,1, 0, 9,8,5, 3'b001, 4'b0001));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, 0, vecs[i].sv, vecs[i].tg, vecs[i].rs, vecs[i].rn);
      #1;
      chk($sformatf("v%0d_we", i), bus.mem_we, vecs[i].we);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_waddr", i), bus.mem_waddr, vecs[i].waddr);
      chk($sformatf("v%0d_raddr", i), bus.mem_raddr, vecs[i].raddr);
      chk($sformatf("v%0d_trig", i), bus.trig_addr, vecs[i].trig);
      chk($sformatf("v%0d_pulses", i),
          {bus.saw_trigger, bus.capture_complete, bus.rd_done}, vecs[i].pulses);
      chk($sformatf("v%0d_flags", i), flags(), vecs[i].flags);
    end

    // Trigger held high from start: ignored during FILL.
    do_reset();
    bus.pre_depth = 4'd3; bus.post_depth = 4'd2;
    cyc(1, 0, 0, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 1, 0, 0);
    chk("held_saw_count", n_saw, 1);
    chk("held_trig_addr", bus.trig_addr, 3);
    chk("held_cmp_count", n_cmp, 1);
    chk("held_waddr", bus.mem_waddr, 5);
    chk("held_flags", flags(), 4'b0001);

    // Wrapping buffer and wrapping readout.
    do_reset();
    bus.pre_depth = 4'd2; bus.post_depth = 4'd3;
    cyc(1, 0, 0, 0, 0, 0);
    repeat (17) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_trig_addr", bus.trig_addr, 1);
    repeat (2) cyc(0, 0, 1, 0, 0, 0);
    chk("wrap_cmp", n_cmp, 1);
    chk("wrap_waddr", bus.mem_waddr, 4);
    cyc(0, 0, 0, 0, 1, 0);
    chk("wrap_rd_first", bus.mem_raddr, 15);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk($sformatf("wrap_rd%0d", k), bus.mem_raddr, k);
    end
    chk("wrap_no_early_done", n_rdd, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_rd_done", bus.rd_done, 1);
    chk("wrap_rd_last", bus.mem_raddr, 3);

    // Zero depths: both pulses on the first triggered sample.
    do_reset();
    bus.pre_depth = 4'd0; bus.post_depth = 4'd0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("zero_armed", flags(), 4'b0110);
    cyc(0, 0, 1, 1, 0, 0);
    chk("zero_both_pulses", {bus.saw_trigger, bus.capture_complete}, 2'b11);
    chk("zero_trig", bus.trig_addr, 0);
    chk("zero_done", flags(), 4'b0001);
    cyc(0, 0, 0, 0, 1, 0);
    chk("zero_raddr", bus.mem_raddr, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("zero_rd_done", bus.rd_done, 1);

    // Abort in POST, start+abort in IDLE, strobes with gaps.
    do_reset();
    bus.pre_depth = 4'd1; bus.post_depth = 4'd4;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("abort_idle", flags(), 4'b1000);
    chk("abort_no_cmp", n_cmp, 0);
    chk("abort_waddr", bus.mem_waddr, 3);
    chk("abort_trig", bus.trig_addr, 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("start_abort_idle", flags(), 4'b1000);
    chk("start_abort_waddr", bus.mem_waddr, 3);
    bus.pre_depth = 4'd2; bus.post_depth = 4'd2;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, (i % 3) == 2, 0, 0, 0);
    chk("gap_waddr", bus.mem_waddr, 3);
    chk("gap_armed", flags(), 4'b0110);
    for (int i = 0; i < 3; i++) cyc(0, 0, (i % 3) == 2, (i % 3) == 2, 0, 0);
    chk("gap_trig", bus.trig_addr, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, (i % 3) == 2, 0, 0, 0);
    chk("gap_cmp", n_cmp, 1);
    chk("gap_done", flags(), 4'b0001);

    // Reset mid-READ, then start taking priority over rd_start in DONE.
    cyc(0, 0, 0, 0, 1, 0);
    chk("gap_rd_first", bus.mem_raddr, 1);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_flags", flags(), 4'b1000);
    chk("midrst_addrs", {bus.mem_waddr, bus.mem_raddr, bus.trig_addr}, 0);
    chk("midrst_pulses", {bus.saw_trigger, bus.capture_complete, bus.rd_done}, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.pre_depth = 4'd1; bus.post_depth = 4'd1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("redo_done", flags(), 4'b0001);
    chk("redo_waddr", bus.mem_waddr, 2);
    cyc(1, 0, 0, 0, 1, 0);
    chk("restart_flags", flags(), 4'b0010);
    chk("restart_waddr", bus.mem_waddr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
